// File: rtl/des_sbox_engine.sv
// DES S-box substitution engine: LANES lookups per cycle over eight boxes, valid/ready on both sides.
// Optional macro SBOX_PERMUTE_EN applies the DES P-permutation to out_data.
module des_sbox_engine #(
    parameter int LANES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);
    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // the producer holds its data stable until that edge.

    localparam int PASSES = 8 / LANES;
    localparam int CW     = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [CW-1:0] LAST_PASS = CW'(PASSES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
            $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
        end
    endgenerate

    // Each table holds 64 nibbles, entry (row*16 + col) counted from the MSB.
    localparam logic [255:0] SBOX_TBL [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175BE3A06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680952_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] b);
        logic [5:0]   idx;
        logic [255:0] tbl;
        idx = {b[5], b[0], b[4:1]};
        tbl = SBOX_TBL[box];
        return tbl[252 - 4 * int'(idx) +: 4];
    endfunction

    logic [1:0]    r_state;
    logic [47:0]   r_in;
    logic [31:0]   r_res;
    logic [CW-1:0] r_pass;

    logic [2:0]    w_box [LANES];
    logic [3:0]    w_nib [LANES];
    logic [31:0]   w_out;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_box[l] = 3'(int'(r_pass) * LANES + l);
            w_nib[l] = sbox_lookup(w_box[l], r_in[42 - 6 * int'(w_box[l]) +: 6]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_in    <= '0;
            r_res   <= '0;
            r_pass  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_in    <= in_data;
                        r_res   <= '0;
                        r_pass  <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        r_res[28 - 4 * int'(w_box[l]) +: 4] <= w_nib[l];
                    end
                    if (r_pass == LAST_PASS) begin
                        r_state <= S_DONE;
                    end else begin
                        r_pass <= r_pass + CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SBOX_PERMUTE_EN
    // P table: output bit i (1 = MSB) takes result bit P_TAB[i-1].
    localparam int P_TAB [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                  2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    always_comb begin
        w_out = '0;
        for (int i = 0; i < 32; i++) begin
            w_out[31 - i] = r_res[32 - P_TAB[i]];
        end
    end
`else
    assign w_out = r_res;
`endif

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_data  = w_out;

endmodule
